// File: rtl/mul_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_pkg
// Description : Shared types and constants for the iterative signed
//               multiply/divide engine (FSM states, op encodings, width).
// Revision    : 1.0 - initial release
// ============================================================================
package mul_div_pkg;

    localparam int C_DEFAULT_WIDTH = 32;

    // Operation select, sampled together with start
    localparam logic MD_MUL = 1'b0;
    localparam logic MD_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage : mul_div_pkg
`default_nettype wire

// File: rtl/mul_div_unit_step.sv
`default_nettype none
// ============================================================================
// Module      : md_step
// Description : One iteration of the multiply/divide engine (combinational).
//               Multiply: radix-2 Booth step + arithmetic shift right.
//               Divide  : restoring step on unsigned magnitudes.
// Ports       : i_op           0 = multiply, 1 = divide
//               i_hi           Booth P (sign-extended) / partial remainder
//               i_lo           Booth Q (multiplier) / dividend-quotient
//               i_qm1          Booth q-1 bit
//               i_opnd         multiplicand A (signed) / divisor |b|
//               o_hi_nxt, o_lo_nxt, o_qm1_nxt   next-iteration values
// Revision    : 1.0 - initial release
// ============================================================================
module md_step
    import mul_div_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH
) (
    input  logic             i_op,
    input  logic [WIDTH:0]   i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic             i_qm1,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH:0]   o_hi_nxt,
    output logic [WIDTH-1:0] o_lo_nxt,
    output logic             o_qm1_nxt
);

    logic [WIDTH:0] w_opnd_ext;
    logic [WIDTH:0] w_booth_sum;
    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_trial;

    always_comb begin
        // P is kept one bit wider than the operand so that P - MIN and
        // similar extremes never overflow before the arithmetic shift.
        w_opnd_ext  = {i_opnd[WIDTH-1], i_opnd};
        w_booth_sum = i_hi;
        case ({i_lo[0], i_qm1})
            2'b01:   w_booth_sum = i_hi + w_opnd_ext;
            2'b10:   w_booth_sum = i_hi - w_opnd_ext;
            default: w_booth_sum = i_hi;
        endcase

        w_shifted = {i_hi[WIDTH-1:0], i_lo[WIDTH-1]};
        w_trial   = w_shifted - {1'b0, i_opnd};

        if (i_op == MD_MUL) begin
            o_hi_nxt  = {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
            o_lo_nxt  = {w_booth_sum[0], i_lo[WIDTH-1:1]};
            o_qm1_nxt = i_lo[0];
        end else begin
            // Trial subtraction borrowed if the top bit is set: restore.
            if (!w_trial[WIDTH]) begin
                o_hi_nxt = w_trial;
                o_lo_nxt = {i_lo[WIDTH-2:0], 1'b1};
            end else begin
                o_hi_nxt = w_shifted;
                o_lo_nxt = {i_lo[WIDTH-2:0], 1'b0};
            end
            o_qm1_nxt = 1'b0;
        end
    end

endmodule : md_step
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative signed multiply/divide engine feeding ZHI/ZLO.
//               mul: result = full 2*WIDTH product.
//               div: result = {remainder, quotient}, truncation toward zero.
// Ports       : clk, reset     clock, async active-high reset
//               start, op      request pulse and op (0 mul / 1 div)
//               a, b           operands (two's complement)
//               busy           high in RUN and FIX
//               done           one-cycle completion pulse
//               result         {hi, lo}
//               div_by_zero    flagged with done on divide by zero
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               div_by_zero
);

    localparam int                 C_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(WIDTH - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [C_CNT_W-1:0]   r_cnt;
    logic                 r_op;
    logic [WIDTH-1:0]     r_a;       // original dividend, for sign and /0 remainder
    logic                 r_b_neg;
    logic                 r_b_zero;
    logic [WIDTH-1:0]     r_opnd;    // A for mul, |b| for div
    logic [WIDTH:0]       r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_qm1;

    logic                 w_accept;
    logic [WIDTH-1:0]     w_a_abs;
    logic [WIDTH-1:0]     w_b_abs;
    logic [WIDTH:0]       w_hi_nxt;
    logic [WIDTH-1:0]     w_lo_nxt;
    logic                 w_qm1_nxt;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: if (start) w_state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (r_cnt == C_LAST) w_state_nxt = FIX;
            end
            FIX: begin
                busy        = 1'b1;
                w_state_nxt = DONE;
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = start ? RUN : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));

    // ------------------------------------------------------------------
    // Operand magnitudes and sign fix-up.  |MIN| = 2^(WIDTH-1) still fits
    // in WIDTH unsigned bits, so MIN/-1 needs no special handling.
    // ------------------------------------------------------------------
    assign w_a_abs = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign w_b_abs = b[WIDTH-1] ? (~b + 1'b1) : b;
    assign w_quot  = (r_a[WIDTH-1] ^ r_b_neg) ? (~r_lo + 1'b1) : r_lo;
    assign w_rem   = r_a[WIDTH-1] ? (~r_hi[WIDTH-1:0] + 1'b1) : r_hi[WIDTH-1:0];

    md_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_op      (r_op),
        .i_hi      (r_hi),
        .i_lo      (r_lo),
        .i_qm1     (r_qm1),
        .i_opnd    (r_opnd),
        .o_hi_nxt  (w_hi_nxt),
        .o_lo_nxt  (w_lo_nxt),
        .o_qm1_nxt (w_qm1_nxt)
    );

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_op        <= MD_MUL;
            r_a         <= '0;
            r_b_neg     <= 1'b0;
            r_b_zero    <= 1'b0;
            r_opnd      <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_qm1       <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else if (w_accept) begin
            r_cnt       <= '0;
            r_op        <= op;
            r_a         <= a;
            r_b_neg     <= b[WIDTH-1];
            r_b_zero    <= (b == '0);
            r_opnd      <= (op == MD_MUL) ? a : w_b_abs;
            r_lo        <= (op == MD_MUL) ? b : w_a_abs;
            r_hi        <= '0;
            r_qm1       <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (r_state == RUN) begin
            r_cnt <= r_cnt + 1'b1;
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_qm1 <= w_qm1_nxt;
        end else if (r_state == FIX) begin
            if (r_op == MD_MUL) begin
                result <= {r_hi[WIDTH-1:0], r_lo};
            end else if (r_b_zero) begin
                result      <= {r_a, {WIDTH{1'b1}}};
                div_by_zero <= 1'b1;
            end else begin
                result <= {w_rem, w_quot};
            end
        end
    end

endmodule : mul_div_unit
`default_nettype wire
